// File: rtl/vga_text_buffer_sync.sv
// vga_text_buffer_sync: double-buffered text store for the VGA renderer.
// The writer fills the back bank. A commit request swaps the banks on the next
// rising edge of vsync. After the swap, the new front is copied into the back
// bank, so later incremental writes start from the frame now on screen.
// Optional macro FRAME_COUNT_EN adds the frame_cnt and swap_frame outputs.
module vga_text_buffer_sync #(
  parameter int DEPTH  = 65,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              VGA_CLK_IN,
  input  logic              rst,
  input  logic              vsync_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              disp_wr_en,
  input  logic [7:0]        disp_wr_data,
  input  logic              commit,
  output logic              wr_ready,
  output logic              busy,
  output logic              commit_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        display_out
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       swap_frame
`endif
);

  typedef enum logic [1:0] {IDLE, PEND, COPY} state_t;

  state_t            r_state;
  logic              r_sel;        // bank index currently shown (front)
  logic              r_vsync_d;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_bank [2][DEPTH];
  logic [7:0]        r_disp [2];

  logic w_vs_rise;
  logic w_front;
  logic w_back;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_vs_rise = vsync_in & ~r_vsync_d;
  assign w_front   = r_sel;
  assign w_back    = ~r_sel;
  assign busy      = (r_state != IDLE);
  assign wr_ready  = (r_state == IDLE) || ((r_state == PEND) && !w_vs_rise);
  assign w_wr_ok   = wr_en && wr_ready && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign w_rd_ok   = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));

  // vsync edge detector
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) r_vsync_d <= 1'b0;
    else     r_vsync_d <= vsync_in;
  end

  // commit / swap / copy-back sequencer
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_idx       <= '0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (r_state)
        IDLE: if (commit) r_state <= PEND;
        PEND: if (w_vs_rise) begin
          // Toggling the selector exposes the back bank and its display byte.
          r_sel   <= ~r_sel;
          r_idx   <= '0;
          r_state <= COPY;
        end
        COPY: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == ADDR_W'(DEPTH-1)) begin
            r_state     <= IDLE;
            commit_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // bank storage: writer updates to back, copy-back from front during COPY
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[0][i] <= '0;
        r_bank[1][i] <= '0;
      end
      r_disp[0] <= '0;
      r_disp[1] <= '0;
    end else if (r_state == COPY) begin
      // wr_ready is low in COPY, so writer updates cannot collide with the copy.
      r_bank[w_back][r_idx] <= r_bank[w_front][r_idx];
      if (r_idx == '0) r_disp[w_back] <= r_disp[w_front];
    end else begin
      if (w_wr_ok)                r_bank[w_back][wr_addr] <= wr_data;
      if (disp_wr_en && wr_ready) r_disp[w_back]          <= disp_wr_data;
    end
  end

  // registered front-bank read port and display byte
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      rd_data     <= '0;
      display_out <= '0;
    end else begin
      rd_data     <= w_rd_ok ? r_bank[w_front][rd_addr] : '0;
      display_out <= r_disp[w_front];
    end
  end

`ifdef FRAME_COUNT_EN
  // frame counter; swap_frame records the count that includes the swapping frame
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      frame_cnt  <= '0;
      swap_frame <= '0;
    end else if (w_vs_rise) begin
      frame_cnt <= frame_cnt + 16'd1;
      if (r_state == PEND) swap_frame <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
